// File: rtl/matb_pkg.sv
// Shared types and default geometry for the matrix-B BRAM controller.
package matb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    SERVE = 2'd2
  } state_t;

  localparam int DEF_P  = 4;
  localparam int DEF_M  = 3;
  localparam int DEF_AW = 8;
  localparam int DEF_DW = 32;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; grants are combinational in the request cycle.
// A tie goes to the requester that did not win last; disabled means no grant.
module rr_arb2
  import matb_pkg::*;
(
  input  logic clkaB,
  input  logic reset,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic last_gnt;

  always_comb begin
    gnt0 = en & req0 & (~req1 | last_gnt);
    gnt1 = en & req1 & (~req0 | ~last_gnt);
  end

  // Starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge clkaB) begin
    if (reset) begin
      last_gnt <= 1'b1;
    end else if (gnt0) begin
      last_gnt <= 1'b0;
    end else if (gnt1) begin
      last_gnt <= 1'b1;
    end
  end

endmodule

// File: rtl/matb_ctrl.sv
// Matrix-B BRAM controller: 1 word/cycle fill from a valid/ready source, then
// round-robin shared read port with grant in cycle t and data/valid in t+1.
module matb_ctrl
  import matb_pkg::*;
#(
  parameter int P  = DEF_P,
  parameter int M  = DEF_M,
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clkaB,
  input  logic          reset,
  input  logic          init_start,
  input  logic          fill_valid,
  input  logic [DW-1:0] fill_data,
  output logic          fill_ready,
  output logic          wr_done,
  output logic          mem_we,
  output logic [AW-1:0] mem_addra,
  output logic [DW-1:0] mem_dina,
  output logic          mem_enb,
  output logic [AW-1:0] mem_addrb,
  input  logic [DW-1:0] mem_doutb,
  input  logic          req0,
  input  logic          req1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          rerr
);

  localparam int          PM      = P * M;
  localparam logic [AW:0] PM_W    = (AW+1)'(PM);
  localparam logic [AW:0] LAST_W  = (AW+1)'(PM - 1);

  state_t        state;
  state_t        state_nxt;
  logic [AW:0]   wptr;
  logic          wr_fire;
  logic          arb_en;
  logic          gnt_any;
  logic [AW-1:0] gaddr;
  logic          in_range;

  // Reset gates the combinational outputs so they read as reset values too.
  assign wr_fire  = (state == FILL) & fill_valid & ~reset;
  assign arb_en   = (state == SERVE) & ~init_start & ~reset;
  assign gnt_any  = gnt0 | gnt1;
  assign gaddr    = gnt0 ? addr0 : (gnt1 ? addr1 : '0);
  assign in_range = {1'b0, gaddr} < PM_W;

  rr_arb2 u_arb (
    .clkaB (clkaB),
    .reset (reset),
    .en    (arb_en),
    .req0  (req0),
    .req1  (req1),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  always_ff @(posedge clkaB) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (init_start) state_nxt = FILL;
      FILL:    if (wr_fire && wptr == LAST_W) state_nxt = SERVE;
      SERVE:   if (init_start) state_nxt = FILL;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fill_ready = (state == FILL) & ~reset;
    mem_we     = wr_fire;
    mem_addra  = wr_fire ? wptr[AW-1:0] : '0;
    mem_dina   = wr_fire ? fill_data : '0;
    mem_enb    = gnt_any & in_range;
    mem_addrb  = gaddr;
  end

  always_ff @(posedge clkaB) begin
    if (reset) begin
      wptr    <= '0;
      wr_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (init_start) wptr <= '0;
        end
        FILL: begin
          if (wr_fire) begin
            wptr <= wptr + 1'b1;
            if (wptr == LAST_W) wr_done <= 1'b1;
          end
        end
        SERVE: begin
          if (init_start) begin
            wptr    <= '0;
            wr_done <= 1'b0;
          end
        end
        default: begin
          wptr <= '0;
        end
      endcase
    end
  end

  // Read response pipeline; an in-flight response survives a re-fill request.
  always_ff @(posedge clkaB) begin
    if (reset) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rerr    <= 1'b0;
    end else begin
      rvalid0 <= gnt0;
      rvalid1 <= gnt1;
      rerr    <= gnt_any & ~in_range;
    end
  end

  assign rdata = ((rvalid0 | rvalid1) & ~rerr) ? mem_doutb : '0;

endmodule
